// File: rtl/apu_pkg.sv
// Shared APU constants: length-counter load table and triangle register addresses.
// Imported by the channel timers and the reusable length counter.
package apu_pkg;

  localparam logic [1:0] REG_TRI_LIN = 2'd0;
  localparam logic [1:0] REG_TRI_LO  = 2'd2;
  localparam logic [1:0] REG_TRI_HI  = 2'd3;

  localparam logic [7:0] LEN_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

endpackage

// File: rtl/apu_length_counter.sv
// Channel length counter shared by triangle/pulse/noise: table load, half-frame decrement, enable clear.
// Count updates one cycle after load/half_frame; disable clears on the next edge and beats any load.
module apu_length_counter
  import apu_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             cpu_clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             halt_i,
  input  logic             load_i,
  input  logic [4:0]       index_i,
  input  logic             half_frame_i,
  output logic [LEN_W-1:0] count_o,
  output logic             active_o
);

  logic [LEN_W-1:0] count_q, count_d;

  // A load in the same cycle as half_frame takes the table value undecremented.
  always_comb begin
    count_d = count_q;
    if (!enable_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = LEN_W'(LEN_TABLE[index_i]);
    end else if (half_frame_i && !halt_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign active_o = (count_q != '0);

endmodule

// File: rtl/apu_triangle_timer.sv
// Triangle period timer, linear counter and length counter; clk_edge toggles per sequencer step, 1 cycle after timer hits 0.
// Optional APU_TRI_ULTRASONIC_MUTE_EN freezes clk_edge while period < 2.
module apu_triangle_timer
  import apu_pkg::*;
#(
  parameter int TIMER_W = 11,
  parameter int LIN_W   = 7,
  parameter int LEN_W   = 8
) (
  input  logic       cpu_clk,
  input  logic       reset,
  input  logic       reg_wr,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_data,
  input  logic       ch_enable,
  input  logic       quarter_frame,
  input  logic       half_frame,
  output logic       clk_edge,
  output logic       length_active,
  output logic       linear_active
);

  logic [TIMER_W-1:0] period_q, period_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [LIN_W-1:0]   linear_q, linear_d;
  logic [LIN_W-1:0]   lin_reload_q, lin_reload_d;
  logic               control_q, control_d;
  logic               reload_flag_q, reload_flag_d;
  logic               clk_edge_q, clk_edge_d;

  logic               hi_wr;
  logic               flag_eff;
  logic               mute;
  logic               gate;
  logic [LEN_W-1:0]   length_cnt;
  logic               len_active;

  assign hi_wr = reg_wr && (reg_addr == REG_TRI_HI);

`ifdef APU_TRI_ULTRASONIC_MUTE_EN
  assign mute = (period_q < TIMER_W'(2));
`else
  assign mute = 1'b0;
`endif

  apu_length_counter #(
    .LEN_W (LEN_W)
  ) u_len (
    .cpu_clk      (cpu_clk),
    .reset        (reset),
    .enable_i     (ch_enable),
    .halt_i       (control_q),
    .load_i       (hi_wr),
    .index_i      (reg_data[7:3]),
    .half_frame_i (half_frame),
    .count_o      (length_cnt),
    .active_o     (len_active)
  );

  always_comb begin
    period_d     = period_q;
    control_d    = control_q;
    lin_reload_d = lin_reload_q;
    if (reg_wr) begin
      case (reg_addr)
        REG_TRI_LIN: begin
          control_d    = reg_data[7];
          lin_reload_d = reg_data[LIN_W-1:0];
        end
        REG_TRI_LO: period_d[7:0] = reg_data;
        REG_TRI_HI: period_d[TIMER_W-1:8] = reg_data[TIMER_W-9:0];
        default: ;
      endcase
    end
  end

  // Quarter tick sees a same-cycle $400B flag but the old control/reload value.
  always_comb begin
    flag_eff      = reload_flag_q | hi_wr;
    linear_d      = linear_q;
    reload_flag_d = flag_eff;
    if (quarter_frame) begin
      if (flag_eff) begin
        linear_d = lin_reload_q;
      end else if (linear_q != '0) begin
        linear_d = linear_q - 1'b1;
      end
      if (!control_q) begin
        reload_flag_d = 1'b0;
      end
    end
  end

  // Gating only freezes clk_edge; the timer keeps running to avoid a DC step.
  assign gate = (linear_q != '0) && (length_cnt != '0) && !mute;

  always_comb begin
    timer_d    = timer_q - 1'b1;
    clk_edge_d = clk_edge_q;
    if (timer_q == '0) begin
      timer_d = period_q;
      if (gate) begin
        clk_edge_d = ~clk_edge_q;
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      period_q      <= '0;
      timer_q       <= '0;
      linear_q      <= '0;
      lin_reload_q  <= '0;
      control_q     <= 1'b0;
      reload_flag_q <= 1'b0;
      clk_edge_q    <= 1'b0;
    end else begin
      period_q      <= period_d;
      timer_q       <= timer_d;
      linear_q      <= linear_d;
      lin_reload_q  <= lin_reload_d;
      control_q     <= control_d;
      reload_flag_q <= reload_flag_d;
      clk_edge_q    <= clk_edge_d;
    end
  end

  assign clk_edge      = clk_edge_q;
  assign length_active = len_active;
  assign linear_active = (linear_q != '0);

endmodule

// File: doc/apu_triangle_timer.md
Name: apu_triangle_timer

Overview:
Producer side of the triangle sequencer step interface. It implements the 11-bit triangle period timer, the linear counter and the length counter, and emits clk_edge. clk_edge is a level that toggles once per sequencer step, and the sequencer advances whenever clk_edge differs from its internal handle. The block sits between the APU register decode/frame counter and the triangle sequencer, and runs entirely on cpu_clk.

Parameters:
TIMER_W, 11, width of period register and timer down-counter
LIN_W, 7, width of linear counter and its reload value
LEN_W, 8, width of length counter

Ports:
cpu_clk  in  1  system/CPU clock; all state on rising edge
reset  in  1  synchronous, active-high
reg_wr  in  1  one-cycle register write strobe
reg_addr  in  2  0=$4008, 2=$400A, 3=$400B; 1 ignored
reg_data  in  8  write data
ch_enable  in  1  $4015 bit 2 level
quarter_frame  in  1  one-cycle frame-counter quarter tick
half_frame  in  1  one-cycle frame-counter half tick
clk_edge  out  1  toggles once per sequencer step
length_active  out  1  length counter != 0 (for $4015 read)
linear_active  out  1  linear counter != 0

Behaviour:
- Reset (synchronous, active-high) clears the following to 0, taking effect on the next cpu_clk edge:
  - period, timer, linear, lin_reload_val, length, control, reload_flag
  - clk_edge=0; length_active=0; linear_active=0
- Register writes:
  - $4008: control <= d[7]; lin_reload_val <= d[6:0].
  - $400A: period[7:0] <= d.
  - $400B: period[10:8] <= d[2:0]; reload_flag <= 1; if ch_enable, length <= LEN_TABLE[d[7:3]].
  - Writes never reload the running timer.
- Timer, evaluated every cpu_clk:
  - If timer==0: timer <= period, and if linear!=0 && length!=0, clk_edge <= ~clk_edge.
  - Otherwise timer <= timer-1.
  - Step period is therefore period+1 cycles. period=0 toggles every cycle while gated on.
- Linear counter, on quarter_frame:
  - If reload_flag: linear <= lin_reload_val.
  - Else if linear!=0: linear <= linear-1.
  - Then, if control==0: reload_flag <= 0.
- Length counter, on half_frame: if control==0 && length!=0, length <= length-1. It saturates at 0 (no wrap).
- ch_enable low forces length <= 0 every cycle; this has priority over a $400B load and over decrement.
- Simultaneous events:
  - $400B write with half_frame in the same cycle: the load wins and no decrement is applied.
  - $400B write with quarter_frame in the same cycle: reload_flag is set and the quarter tick uses the new flag, so the linear counter reloads.
  - $4008 write with quarter_frame in the same cycle: the tick uses the old control and lin_reload_val.
- Gating freezes clk_edge at its current level; the timer keeps counting. This avoids a DC pop in the sequencer output.
- Outputs are registered-equivalent: length_active and linear_active are combinational compares of registered counters. Latency from timer reaching 0 to clk_edge change is 1 cycle.
- Reset asserted mid-operation clears everything in one cycle, including any pending reload_flag.

Optional Feature:
APU_TRI_ULTRASONIC_MUTE_EN
- Defined: when period < 2, clk_edge does not toggle even if gated on; the timer still counts. This suppresses ultrasonic aliasing.
- Undefined: period 0/1 toggle exactly per the timer rule.

Decomposition:
- Package apu_pkg holds:
  - LEN_TABLE, a 32x8 constant: {10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30}.
  - Register address localparams REG_TRI_LIN=0, REG_TRI_LO=2, REG_TRI_HI=3.
- The length counter is natural as sub-module apu_length_counter, reusable by the pulse and noise channels. Its interface is enable, halt, load strobe, index, half_frame, count/active.

Test Plan:
1. Reset, then ch_enable=1, write $4008=0x7F, $400A=0x03, $400B=0x08 (LEN idx 1 -> 254), pulse quarter_frame -> linear=127, length=254, clk_edge toggles every 4 cycles.
2. From scenario 1, write $4008=0x00 and apply 127 quarter_frame pulses -> linear reaches 0, clk_edge freezes, linear_active=0, timer still cycles.
3. Length index 0x03 (value 2), control=0, two half_frame pulses -> length_active drops after the second pulse and toggling stops; with control=1 the length holds at 2.
4. Load length, then drop ch_enable -> length_active=0 the next cycle; a $400B write while ch_enable=0 leaves length at 0 but sets reload_flag.
5. $400B write in the same cycle as half_frame -> length equals the table value with no decrement; $400B with quarter_frame in the same cycle -> linear reloads.
6. Assert reset mid-toggle -> clk_edge=0 and all counters 0 the next cycle. With APU_TRI_ULTRASONIC_MUTE_EN defined, period=1 -> clk_edge never toggles.
